// File: rtl/uart_core_fifo.sv
// uart_core_fifo: full-duplex UART with oversampled RX, RX FIFO and per-word parity/framing flags.
// Define UART_LOOPBACK_EN to add a loopback input that routes tx into the RX synchroniser.
module uart_core_fifo #(
   parameter int DATA_MAX   = 8,
   parameter int OVS        = 16,
   parameter int DIV_W      = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIV_W-1:0]    baud_div,
   input  logic [3:0]          data_len,
   input  logic                parity_en,
   input  logic                parity_type,
   input  logic                stop2,
   output logic                cfg_err,
   input  logic                tx_valid,
   input  logic [DATA_MAX-1:0] tx_data,
   output logic                tx_ready,
   output logic                tx_busy,
   output logic                tx,
   input  logic                rx,
`ifdef UART_LOOPBACK_EN
   input  logic                loopback,
`endif
   output logic                rx_valid,
   output logic [DATA_MAX-1:0] rx_data,
   output logic                rx_perr,
   output logic                rx_ferr,
   input  logic                rx_ready,
   output logic                rx_ovf
);
   localparam int OW = $clog2(OVS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [OW-1:0] OVS_END  = OW'(OVS - 1);
   localparam logic [OW-1:0] HALF_END = OW'(OVS / 2 - 1);

   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP1, R_STOP2, R_PUSH} rx_state_t;

   tx_state_t           ts_q, ts_d;
   logic [DIV_W-1:0]    tdiv_q, tdiv_d, tpre_q, tpre_d;
   logic [OW-1:0]       tovs_q, tovs_d;
   logic [3:0]          tbit_q, tbit_d, tlen_q, tlen_d;
   logic [DATA_MAX-1:0] tsh_q, tsh_d, msk;
   logic                tpen_q, tpen_d, tst2_q, tst2_d, tpar_q, tpar_d, tx_q, tx_d;
   logic                ttick, tend, accept;

   rx_state_t           rs_q, rs_d;
   logic [DIV_W-1:0]    rdiv_q, rdiv_d, rpre_q, rpre_d;
   logic [OW-1:0]       rovs_q, rovs_d;
   logic [3:0]          rbit_q, rbit_d, rlen_q, rlen_d;
   logic [DATA_MAX-1:0] rsh_q, rsh_d;
   logic                rpen_q, rpen_d, rpt_q, rpt_d, rst2_q, rst2_d;
   logic                rperr_q, rperr_d, rferr_q, rferr_d;
   logic                s1_q, s2_q, rin, rtick, rend, rhalf, push;

   logic [DATA_MAX+1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wp_q, rp_q;
   logic [CW-1:0]       cnt_q;
   logic                pop, full, wr, ovf_q;

   assign cfg_err  = (data_len < 4'd5) || (32'(data_len) > 32'(DATA_MAX));
   assign tx_ready = (ts_q == T_IDLE) && !cfg_err;
   assign tx_busy  = ts_q != T_IDLE;
   assign tx       = tx_q;
   assign accept   = tx_valid && tx_ready;
   assign ttick    = tpre_q == tdiv_q;
   assign tend     = ttick && (tovs_q == OVS_END);

   always_comb
      for (int i = 0; i < DATA_MAX; i++) msk[i] = i < int'(data_len);

   always_comb begin
      ts_d   = ts_q;
      tdiv_d = tdiv_q;
      tlen_d = tlen_q;
      tpen_d = tpen_q;
      tst2_d = tst2_q;
      tpar_d = tpar_q;
      tbit_d = tbit_q;
      tsh_d  = tsh_q;
      tpre_d = ttick ? '0 : tpre_q + DIV_W'(1);
      tovs_d = tend ? '0 : tovs_q + OW'(ttick);
      if (ts_q == T_IDLE) begin
         tpre_d = '0;
         tovs_d = '0;
         if (accept) begin
            ts_d   = T_START;
            tdiv_d = baud_div;
            tlen_d = data_len;
            tpen_d = parity_en;
            tst2_d = stop2;
            tpar_d = (^(tx_data & msk)) ^ parity_type;
            tsh_d  = tx_data;
            tbit_d = '0;
         end
      end else if (tend) begin
         case (ts_q)
            T_START: ts_d = T_DATA;
            T_DATA: begin
               tsh_d  = tsh_q >> 1;
               tbit_d = tbit_q + 4'd1;
               if (tbit_q == tlen_q - 4'd1) ts_d = tpen_q ? T_PAR : T_STOP1;
            end
            T_PAR:   ts_d = T_STOP1;
            T_STOP1: ts_d = tst2_q ? T_STOP2 : T_IDLE;
            default: ts_d = T_IDLE;
         endcase
      end
      // tx is registered from the next state so it changes on the same edge as the FSM
      tx_d = (ts_d == T_START) ? 1'b0 : (ts_d == T_DATA) ? tsh_d[0] : (ts_d == T_PAR) ? tpar_d : 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q   <= T_IDLE;
         tdiv_q <= '0;
         tpre_q <= '0;
         tovs_q <= '0;
         tbit_q <= '0;
         tlen_q <= '0;
         tsh_q  <= '0;
         tpen_q <= 1'b0;
         tst2_q <= 1'b0;
         tpar_q <= 1'b0;
         tx_q   <= 1'b1;
      end else begin
         ts_q   <= ts_d;
         tdiv_q <= tdiv_d;
         tpre_q <= tpre_d;
         tovs_q <= tovs_d;
         tbit_q <= tbit_d;
         tlen_q <= tlen_d;
         tsh_q  <= tsh_d;
         tpen_q <= tpen_d;
         tst2_q <= tst2_d;
         tpar_q <= tpar_d;
         tx_q   <= tx_d;
      end
   end

`ifdef UART_LOOPBACK_EN
   assign rin = loopback ? tx_q : rx;
`else
   assign rin = rx;
`endif

   assign rtick = rpre_q == rdiv_q;
   assign rend  = rtick && (rovs_q == OVS_END);
   assign rhalf = rtick && (rovs_q == HALF_END);
   assign push  = rs_q == R_PUSH;

   always_comb begin
      rs_d    = rs_q;
      rdiv_d  = rdiv_q;
      rlen_d  = rlen_q;
      rpen_d  = rpen_q;
      rpt_d   = rpt_q;
      rst2_d  = rst2_q;
      rbit_d  = rbit_q;
      rsh_d   = rsh_q;
      rperr_d = rperr_q;
      rferr_d = rferr_q;
      rpre_d  = rtick ? '0 : rpre_q + DIV_W'(1);
      rovs_d  = rend ? '0 : rovs_q + OW'(rtick);
      case (rs_q)
         R_IDLE: begin
            rpre_d = '0;
            rovs_d = '0;
            if (!s2_q) begin
               rs_d    = R_START;
               rdiv_d  = baud_div;
               rlen_d  = data_len;
               rpen_d  = parity_en;
               rpt_d   = parity_type;
               rst2_d  = stop2;
               rbit_d  = '0;
               rsh_d   = '0;
               rperr_d = 1'b0;
               rferr_d = 1'b0;
            end
         end
         R_START: if (rhalf) begin
            rovs_d = '0;
            rs_d   = s2_q ? R_IDLE : R_DATA;
         end
         R_DATA: if (rend) begin
            rsh_d  = rsh_q | (DATA_MAX'(s2_q) << rbit_q);
            rbit_d = rbit_q + 4'd1;
            if (rbit_q == rlen_q - 4'd1) rs_d = rpen_q ? R_PAR : R_STOP1;
         end
         R_PAR: if (rend) begin
            rperr_d = s2_q ^ (^rsh_q) ^ rpt_q;
            rs_d    = R_STOP1;
         end
         R_STOP1: if (rend) begin
            rferr_d = !s2_q;
            rs_d    = rst2_q ? R_STOP2 : R_PUSH;
         end
         R_STOP2: if (rend) begin
            rferr_d = rferr_q | !s2_q;
            rs_d    = R_PUSH;
         end
         default: rs_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         rs_q    <= R_IDLE;
         rdiv_q  <= '0;
         rpre_q  <= '0;
         rovs_q  <= '0;
         rbit_q  <= '0;
         rlen_q  <= '0;
         rsh_q   <= '0;
         rpen_q  <= 1'b0;
         rpt_q   <= 1'b0;
         rst2_q  <= 1'b0;
         rperr_q <= 1'b0;
         rferr_q <= 1'b0;
      end else begin
         s1_q    <= rin;
         s2_q    <= s1_q;
         rs_q    <= rs_d;
         rdiv_q  <= rdiv_d;
         rpre_q  <= rpre_d;
         rovs_q  <= rovs_d;
         rbit_q  <= rbit_d;
         rlen_q  <= rlen_d;
         rsh_q   <= rsh_d;
         rpen_q  <= rpen_d;
         rpt_q   <= rpt_d;
         rst2_q  <= rst2_d;
         rperr_q <= rperr_d;
         rferr_q <= rferr_d;
      end
   end

   assign pop      = rx_valid && rx_ready;
   assign full     = cnt_q == CW'(FIFO_DEPTH);
   assign wr       = push && (!full || pop);
   assign rx_valid = cnt_q != '0;
   assign rx_ovf   = ovf_q;
   assign {rx_ferr, rx_perr, rx_data} = rx_valid ? mem_q[rp_q] : '0;

   always_ff @(posedge clk)
      if (wr) mem_q[wp_q] <= {rferr_q, rperr_q, rsh_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_q + AW'(wr);
         rp_q  <= rp_q + AW'(pop);
         cnt_q <= cnt_q + CW'(wr) - CW'(pop);
         ovf_q <= push && full && !pop;
      end
   end
endmodule
